wb_regfile: RTL and testbench

Write-back end of the register-file datapath: captures the MEM-stage result into the MEM/WB pipeline register, commits it to a 32×32 general-purpose register file, and serves the two ID-stage read ports. Sits beneath the ID-stage forwarding logic, which handles EX and MEM producers. This block covers the remaining hazard, a WB-stage write landing in the same cycle as an ID read, via internal write-through. It also keeps a retired-instruction counter for debug.

---
 rtl/wb_regfile_if.sv | 41 ++++
 rtl/wb_regfile.sv | 78 +++++++
 tb/tb_wb_regfile.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Bus bundle for the write-back / register-file block: MEM-stage capture,
// pipeline control, ID read ports and the registered WB status.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              mem_valid;
  logic              mem_reg_write_en;
  logic [ADDR_W-1:0] mem_reg_write_addr;
  logic [DATA_W-1:0] mem_reg_write_data;
  logic              wb_stall;
  logic              wb_flush;
  logic              read_en_1;
  logic              read_en_2;
  logic [ADDR_W-1:0] read_addr_1;
  logic [ADDR_W-1:0] read_addr_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic              wb_reg_write_en;
  logic [ADDR_W-1:0] wb_reg_write_addr;
  logic [DATA_W-1:0] wb_reg_write_data;
  logic [31:0]       retired_count;

  modport master (
    output mem_valid, mem_reg_write_en, mem_reg_write_addr, mem_reg_write_data,
    output wb_stall, wb_flush,
    output read_en_1, read_en_2, read_addr_1, read_addr_2,
    input  read_data_1, read_data_2,
    input  wb_reg_write_en, wb_reg_write_addr, wb_reg_write_data,
    input  retired_count
  );

  modport slave (
    input  mem_valid, mem_reg_write_en, mem_reg_write_addr, mem_reg_write_data,
    input  wb_stall, wb_flush,
    input  read_en_1, read_en_2, read_addr_1, read_addr_2,
    output read_data_1, read_data_2,
    output wb_reg_write_en, wb_reg_write_addr, wb_reg_write_data,
    output retired_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB pipeline register, 32x32 register file with
// WB-to-ID write-through on both read ports, and a retired-instruction counter.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic              valid;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } memwb_t;

  memwb_t            wb_q;
  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  retired_q;

  // MEM/WB register; wen is qualified by valid so bubbles never write
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_q <= '0;
    end else if (bus.wb_flush) begin
      wb_q <= '0;
    end else if (!bus.wb_stall) begin
      wb_q.valid <= bus.mem_valid;
      wb_q.wen   <= bus.mem_reg_write_en & bus.mem_valid;
      wb_q.waddr <= bus.mem_reg_write_addr;
      wb_q.wdata <= bus.mem_reg_write_data;
    end
  end

  // Commit ignores stall: re-writing the held value is harmless
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wb_q.wen && (wb_q.waddr != '0)) begin
      regs[wb_q.waddr] <= wb_q.wdata;
    end
  end

  // An instruction retires on the edge it leaves WB un-stalled and un-flushed
  always_ff @(posedge clk) begin
    if (!rst) begin
      retired_q <= '0;
    end else if (wb_q.valid && !bus.wb_stall && !bus.wb_flush) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic              en,
                                                  input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] data;
    data = '0;
    if (!en || (addr == '0)) data = '0;
    else if (wb_q.wen && (wb_q.waddr == addr)) data = wb_q.wdata;
    else data = regs[addr];
    return data;
  endfunction

  always_comb begin
    bus.read_data_1 = read_port(bus.read_en_1, bus.read_addr_1);
    bus.read_data_2 = read_port(bus.read_en_2, bus.read_addr_2);
  end

  assign bus.wb_reg_write_en   = wb_q.wen;
  assign bus.wb_reg_write_addr = wb_q.waddr;
  assign bus.wb_reg_write_data = wb_q.wdata;
  assign bus.retired_count     = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus pushes expected outputs into a
// queue, a negedge monitor pops and compares them against the DUT.
module tb_wb_regfile;

  typedef enum int {RD1, RD2, WEN, WADDR, WDATA, CNT} sig_e;
  typedef struct {
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   n_total;
  int   n_pass;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every expectation queued during a cycle is checked at negedge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sig)
        RD1:     act = bus.read_data_1;
        RD2:     act = bus.read_data_2;
        WEN:     act = 32'(bus.wb_reg_write_en);
        WADDR:   act = 32'(bus.wb_reg_write_addr);
        WDATA:   act = bus.wb_reg_write_data;
        default: act = bus.retired_count;
      endcase
      n_total++;
      if (act === e.val) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
    end
  end

  task automatic push(input sig_e s, input logic [31:0] v, input string nm);
    exp_t e;
    e.sig = s; e.val = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.mem_valid          = v;
    bus.mem_reg_write_en   = we;
    bus.mem_reg_write_addr = a;
    bus.mem_reg_write_data = d;
  endtask

  task automatic rd1(input logic en, input logic [4:0] a);
    bus.read_en_1 = en; bus.read_addr_1 = a;
  endtask

  task automatic rd2(input logic en, input logic [4:0] a);
    bus.read_en_2 = en; bus.read_addr_2 = a;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b0;
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    bus.wb_stall = 1'b0;
    bus.wb_flush = 1'b0;
    rd1(1'b1, 5'd5);
    rd2(1'b1, 5'd31);

    // Reset
    step(); step();
    push(RD1, 32'h0, "reset_rd1_r5");
    push(RD2, 32'h0, "reset_rd2_r31");
    push(CNT, 32'd0, "reset_count");
    push(WEN, 32'd0, "reset_wen");
    push(WADDR, 32'd0, "reset_waddr");
    push(WDATA, 32'd0, "reset_wdata");
    step();
    rst = 1'b1;

    // Write-through then array read
    mem(1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
    step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    rd1(1'b1, 5'd7);
    push(RD1, 32'hDEADBEEF, "wt_r7_bypass");
    push(WEN, 32'd1, "wt_wen");
    push(WADDR, 32'd7, "wt_waddr");
    push(CNT, 32'd0, "wt_count_before_retire");
    step();
    push(RD1, 32'hDEADBEEF, "wt_r7_array");
    push(WEN, 32'd0, "wt_wen_after");
    push(CNT, 32'd1, "wt_count_retired");

    // Register 0 never written
    mem(1'b1, 1'b1, 5'd0, 32'h12345678);
    step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    rd2(1'b1, 5'd0);
    push(RD2, 32'h0, "r0_during_wb");
    push(WDATA, 32'h12345678, "r0_wdata");
    step();
    push(RD2, 32'h0, "r0_after");
    push(CNT, 32'd2, "r0_count");

    // Bubble with wen set must not write
    mem(1'b0, 1'b1, 5'd3, 32'h55);
    step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    push(WEN, 32'd0, "bubble_wen");
    step();
    rd1(1'b1, 5'd3);
    push(RD1, 32'h0, "bubble_r3");
    push(CNT, 32'd2, "bubble_count");

    // Flush at capture edge
    mem(1'b1, 1'b1, 5'd4, 32'hAA);
    bus.wb_flush = 1'b1;
    step();
    bus.wb_flush = 1'b0;
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    push(WEN, 32'd0, "flush_wen");
    push(WADDR, 32'd0, "flush_waddr");
    push(WDATA, 32'd0, "flush_wdata");
    step();
    rd1(1'b1, 5'd4);
    push(RD1, 32'h0, "flush_r4");
    push(CNT, 32'd2, "flush_count");

    // Stall held three edges, then release
    mem(1'b1, 1'b1, 5'd9, 32'h1);
    step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    bus.wb_stall = 1'b1;
    rd1(1'b1, 5'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      push(WEN, 32'd1, "stall_wen");
      push(WADDR, 32'd9, "stall_waddr");
      push(WDATA, 32'h1, "stall_wdata");
      push(RD1, 32'h1, "stall_r9");
      push(CNT, 32'd2, "stall_count_held");
    end
    bus.wb_stall = 1'b0;
    step();
    push(CNT, 32'd3, "stall_release_count");
    push(WEN, 32'd0, "stall_release_wen");
    push(RD1, 32'h1, "stall_r9_array");

    // Flush and stall together: flush wins, WB write still commits
    mem(1'b1, 1'b1, 5'd10, 32'h10);
    step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    bus.wb_stall = 1'b1;
    bus.wb_flush = 1'b1;
    step();
    bus.wb_stall = 1'b0;
    bus.wb_flush = 1'b0;
    rd1(1'b1, 5'd10);
    push(WEN, 32'd0, "fs_wen");
    push(WADDR, 32'd0, "fs_waddr");
    push(CNT, 32'd3, "fs_count");
    push(RD1, 32'h10, "fs_r10");

    // Read enable gating
    mem(1'b1, 1'b1, 5'd2, 32'h77);
    step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    step();
    rd2(1'b0, 5'd2);
    push(RD2, 32'h0, "ren_off_r2");
    push(CNT, 32'd4, "ren_count");
    step();
    rd2(1'b1, 5'd2);
    push(RD2, 32'h77, "ren_on_r2");

    // Both ports on the WB address
    mem(1'b1, 1'b1, 5'd11, 32'hCAFE);
    step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    rd1(1'b1, 5'd11);
    rd2(1'b1, 5'd11);
    push(RD1, 32'hCAFE, "dual_rd1");
    push(RD2, 32'hCAFE, "dual_rd2");
    step();

    // Bypass beats stale array contents
    mem(1'b1, 1'b1, 5'd7, 32'h1111);
    step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    rd1(1'b1, 5'd7);
    rd2(1'b0, 5'd7);
    push(RD1, 32'h1111, "bypass_over_stale");
    push(RD2, 32'h0, "bypass_ren_off");
    push(CNT, 32'd5, "bypass_count");
    step();
    rd2(1'b1, 5'd11);
    push(RD1, 32'h1111, "r7_new_array");
    push(RD2, 32'hCAFE, "r11_array");
    push(CNT, 32'd6, "final_count");

    step(); step();
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
